// File: rtl/multicycle_control_pkg.sv
// Shared types and encodings for the multicycle control unit.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package multicycle_control_pkg;

    // Controller states; the 4-bit encoding is exported on the debug port.
    typedef enum logic [3:0] {
        ST_FETCH  = 4'd0,
        ST_DECODE = 4'd1,
        ST_MEMADR = 4'd2,
        ST_MEMRD  = 4'd3,
        ST_MEMWB  = 4'd4,
        ST_MEMWR  = 4'd5,
        ST_EXEC   = 4'd6,
        ST_ALUWB  = 4'd7,
        ST_BRANCH = 4'd8,
        ST_JUMP   = 4'd9,
        ST_UPPER  = 4'd10,
        ST_HALT   = 4'd11
    } state_t;

    // Major opcodes, instruction bits [6:2].
    localparam logic [4:0] OPC_LOAD   = 5'd0;
    localparam logic [4:0] OPC_OP_IMM = 5'd4;
    localparam logic [4:0] OPC_AUIPC  = 5'd5;
    localparam logic [4:0] OPC_STORE  = 5'd8;
    localparam logic [4:0] OPC_OP     = 5'd12;
    localparam logic [4:0] OPC_LUI    = 5'd13;
    localparam logic [4:0] OPC_BRANCH = 5'd24;
    localparam logic [4:0] OPC_JALR   = 5'd25;
    localparam logic [4:0] OPC_JAL    = 5'd27;
    localparam logic [4:0] OPC_SYSTEM = 5'd28;

    // ALU operation class.
    localparam logic [1:0] ALUOP_ADD = 2'b00;
    localparam logic [1:0] ALUOP_BR  = 2'b01;
    localparam logic [1:0] ALUOP_R   = 2'b10;
    localparam logic [1:0] ALUOP_I   = 2'b11;

    // ALU operand A select.
    localparam logic [1:0] ALU_A_PC    = 2'd0;
    localparam logic [1:0] ALU_A_RS1   = 2'd1;
    localparam logic [1:0] ALU_A_ZERO  = 2'd2;
    localparam logic [1:0] ALU_A_OLDPC = 2'd3;

    // ALU operand B select.
    localparam logic [1:0] ALU_B_RS2  = 2'd0;
    localparam logic [1:0] ALU_B_IMM  = 2'd1;
    localparam logic [1:0] ALU_B_FOUR = 2'd2;

    // Register-file write-back source.
    localparam logic [1:0] WB_ALU = 2'd0;
    localparam logic [1:0] WB_MEM = 2'd1;
    localparam logic [1:0] WB_PC  = 2'd2;

    // Fault codes reported while halted.
    localparam logic [1:0] FAULT_NONE    = 2'b00;
    localparam logic [1:0] FAULT_ILLEGAL = 2'b01;
    localparam logic [1:0] FAULT_MEM     = 2'b10;
    localparam logic [1:0] FAULT_ECALL   = 2'b11;

    // States that issue a memory request and therefore own the wait timer.
    function automatic logic is_mem_state(state_t s);
        return (s == ST_FETCH) || (s == ST_MEMRD) || (s == ST_MEMWR);
    endfunction

endpackage

// File: rtl/multicycle_control_mem_wait_timer.sv
// Counts consecutive memory-wait cycles and flags a timeout on the last allowed one.
// Latency: o_timeout is combinational in the cycle the count would reach MEM_TIMEOUT.
// Backpressure: none; a ready memory (no i_wait) never times out in that cycle.
//
// Ports: clk/rst (sync, active-high); i_clear zeroes the count; i_wait marks a
// request cycle without mem_ready; o_timeout asserts when this wait is the
// MEM_TIMEOUT-th consecutive one.
module mem_wait_timer #(
    parameter int MEM_TIMEOUT = 16
) (
    input  logic clk,
    input  logic rst,
    input  logic i_clear,
    input  logic i_wait,
    output logic o_timeout
);

    // Count only needs to hold MEM_TIMEOUT-1; the final wait is detected combinationally.
    localparam int CW = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT);

    logic [CW-1:0] r_cnt;

    assign o_timeout = i_wait && (r_cnt == CW'(MEM_TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (rst || i_clear) begin
            r_cnt <= '0;
        end else if (i_wait && !o_timeout) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/multicycle_control.sv
// Multicycle RISC-style control FSM: Moore decode of datapath controls, retire count, fault halt.
// Latency: load 5 cycles, store/R/I 4, branch/jump/upper 3 with a zero-wait memory.
// Backpressure: FETCH/MEMRD/MEMWR hold until mem_ready; MEM_TIMEOUT consecutive waits halt with fault.
//
// Ports: clk, rst (sync, active-high); opcode = IR[6:2]; mem_ready, branch_taken
// from memory/datapath. Outputs: memory controls (mem_req, mem_we, iord), register
// enables, ALU/wb/pc selects, halted, fault, retired count and debug state.
module multicycle_control
    import multicycle_control_pkg::*;
#(
    parameter int MEM_TIMEOUT   = 16,
    parameter int CNT_W         = 32,
    parameter bit HALT_ON_ECALL = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       opcode,
    input  logic             mem_ready,
    input  logic             branch_taken,
    output logic             mem_req,
    output logic             mem_we,
    output logic             iord,
    output logic             ir_write,
    output logic             pc_write,
    output logic             reg_write,
    output logic [1:0]       alu_src_a,
    output logic [1:0]       alu_src_b,
    output logic [1:0]       alu_op,
    output logic [1:0]       wb_sel,
    output logic             pc_src,
    output logic             halted,
    output logic [1:0]       fault,
    output logic [CNT_W-1:0] retired,
    output logic [3:0]       state
);

    state_t           r_state;
    state_t           w_next;
    logic [1:0]       r_fault;
    logic [1:0]       w_fault_code;
    logic [CNT_W-1:0] r_retired;

    logic w_mem_req;
    logic w_mem_we;
    logic w_ir_write;
    logic w_pc_write;
    logic w_reg_write;
    logic w_timeout;
    logic w_wait;
    logic w_clear;
    logic w_enter_halt;
    logic w_enter_fetch;

    // A wait is any request cycle the memory did not complete.
    assign w_wait  = w_mem_req && !mem_ready;
    // Fresh count on each new memory state and after every completed access.
    assign w_clear = mem_ready || ((w_next != r_state) && is_mem_state(w_next));

    mem_wait_timer #(
        .MEM_TIMEOUT (MEM_TIMEOUT)
    ) u_wait_timer (
        .clk       (clk),
        .rst       (rst),
        .i_clear   (w_clear),
        .i_wait    (w_wait),
        .o_timeout (w_timeout)
    );

    // Next-state and Moore output decode; branch_taken and mem_ready only gate enables.
    always_comb begin
        w_next       = r_state;
        w_fault_code = FAULT_NONE;
        w_mem_req    = 1'b0;
        w_mem_we     = 1'b0;
        iord         = 1'b0;
        w_ir_write   = 1'b0;
        w_pc_write   = 1'b0;
        w_reg_write  = 1'b0;
        alu_src_a    = ALU_A_PC;
        alu_src_b    = ALU_B_RS2;
        alu_op       = ALUOP_ADD;
        wb_sel       = WB_ALU;
        pc_src       = 1'b0;
        halted       = 1'b0;

        case (r_state)
            ST_FETCH: begin
                w_mem_req = 1'b1;
                alu_src_b = ALU_B_FOUR;
                if (mem_ready) begin
                    w_ir_write = 1'b1;
                    w_pc_write = 1'b1;
                    w_next     = ST_DECODE;
                end else if (w_timeout) begin
                    w_next       = ST_HALT;
                    w_fault_code = FAULT_MEM;
                end
            end

            ST_DECODE: begin
                // Branch/jump target is precomputed from the old PC here.
                alu_src_a = ALU_A_OLDPC;
                alu_src_b = ALU_B_IMM;
                case (opcode)
                    OPC_LOAD, OPC_STORE: w_next = ST_MEMADR;
                    OPC_OP_IMM, OPC_OP:  w_next = ST_EXEC;
                    OPC_BRANCH:          w_next = ST_BRANCH;
                    OPC_JALR, OPC_JAL:   w_next = ST_JUMP;
                    OPC_AUIPC, OPC_LUI:  w_next = ST_UPPER;
                    OPC_SYSTEM: begin
                        if (HALT_ON_ECALL) begin
                            w_next       = ST_HALT;
                            w_fault_code = FAULT_ECALL;
                        end else begin
                            w_next = ST_FETCH;
                        end
                    end
                    default: begin
                        w_next       = ST_HALT;
                        w_fault_code = FAULT_ILLEGAL;
                    end
                endcase
            end

            ST_MEMADR: begin
                alu_src_a = ALU_A_RS1;
                alu_src_b = ALU_B_IMM;
                w_next    = (opcode == OPC_LOAD) ? ST_MEMRD : ST_MEMWR;
            end

            ST_MEMRD: begin
                w_mem_req = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_next = ST_MEMWB;
                end else if (w_timeout) begin
                    w_next       = ST_HALT;
                    w_fault_code = FAULT_MEM;
                end
            end

            ST_MEMWB: begin
                w_reg_write = 1'b1;
                wb_sel      = WB_MEM;
                w_next      = ST_FETCH;
            end

            ST_MEMWR: begin
                w_mem_req = 1'b1;
                w_mem_we  = 1'b1;
                iord      = 1'b1;
                if (mem_ready) begin
                    w_next = ST_FETCH;
                end else if (w_timeout) begin
                    w_next       = ST_HALT;
                    w_fault_code = FAULT_MEM;
                end
            end

            ST_EXEC: begin
                alu_src_a = ALU_A_RS1;
                if (opcode == OPC_OP) begin
                    alu_src_b = ALU_B_RS2;
                    alu_op    = ALUOP_R;
                end else if (opcode == OPC_OP_IMM) begin
                    alu_src_b = ALU_B_IMM;
                    alu_op    = ALUOP_I;
                end
                w_next = ST_ALUWB;
            end

            ST_ALUWB: begin
                w_reg_write = 1'b1;
                wb_sel      = WB_ALU;
                w_next      = ST_FETCH;
            end

            ST_BRANCH: begin
                alu_src_a  = ALU_A_RS1;
                alu_src_b  = ALU_B_RS2;
                alu_op     = ALUOP_BR;
                pc_src     = 1'b1;
                w_pc_write = branch_taken;
                w_next     = ST_FETCH;
            end

            ST_JUMP: begin
                // Link write of PC+4 happens alongside the PC redirect.
                w_reg_write = 1'b1;
                wb_sel      = WB_PC;
                w_pc_write  = 1'b1;
                if (opcode == OPC_JAL) begin
                    pc_src = 1'b1;
                end else if (opcode == OPC_JALR) begin
                    alu_src_a = ALU_A_RS1;
                    alu_src_b = ALU_B_IMM;
                    alu_op    = ALUOP_ADD;
                    pc_src    = 1'b0;
                end
                w_next = ST_FETCH;
            end

            ST_UPPER: begin
                alu_src_a   = (opcode == OPC_AUIPC) ? ALU_A_OLDPC : ALU_A_ZERO;
                alu_src_b   = ALU_B_IMM;
                alu_op      = ALUOP_ADD;
                w_reg_write = 1'b1;
                wb_sel      = WB_ALU;
                w_next      = ST_FETCH;
            end

            ST_HALT: begin
                halted = 1'b1;
                w_next = ST_HALT;
            end

            default: begin
                w_next = ST_FETCH;
            end
        endcase
    end

    assign w_enter_halt  = (w_next == ST_HALT) && (r_state != ST_HALT);
    assign w_enter_fetch = (w_next == ST_FETCH) && (r_state != ST_FETCH);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_FETCH;
            r_fault   <= FAULT_NONE;
            r_retired <= '0;
        end else begin
            r_state <= w_next;
            if (w_enter_halt) begin
                r_fault <= w_fault_code;
            end
            if (w_enter_fetch) begin
                r_retired <= r_retired + 1'b1;
            end
        end
    end

    // Side-effecting controls are suppressed while reset is held.
    assign mem_req   = w_mem_req   && !rst;
    assign mem_we    = w_mem_we    && !rst;
    assign ir_write  = w_ir_write  && !rst;
    assign pc_write  = w_pc_write  && !rst;
    assign reg_write = w_reg_write && !rst;

    // Fault is only ever loaded on HALT entry and cleared by reset, so it reads 00 elsewhere.
    assign fault   = r_fault;
    assign retired = r_retired;
    assign state   = r_state;

endmodule

// File: tb/tb_multicycle_control.sv
module tb_multicycle_control;
    import multicycle_control_pkg::*;

    typedef struct packed {
        logic [3:0] st;
        logic       mem_req;
        logic       mem_we;
        logic       iord;
        logic       ir_write;
        logic       pc_write;
        logic       reg_write;
        logic [1:0] src_a;
        logic [1:0] src_b;
        logic [1:0] alu_op;
        logic [1:0] wb_sel;
        logic       pc_src;
        logic       halted;
        logic [1:0] fault;
        logic [3:0] retired;
    } snap_t;

    typedef struct packed {
        logic       rst;
        logic       mr;
        logic       bt;
        logic [4:0] op;
    } stim_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [4:0] opcode;
    logic       mem_ready;
    logic       branch_taken;

    logic       mem_req, mem_we, iord, ir_write, pc_write, reg_write, pc_src, halted;
    logic [1:0] alu_src_a, alu_src_b, alu_op, wb_sel, fault;
    logic [3:0] retired;
    logic [3:0] state;

    logic       mem_req2, mem_we2, iord2, ir_write2, pc_write2, reg_write2, pc_src2, halted2;
    logic [1:0] alu_src_a2, alu_src_b2, alu_op2, wb_sel2, fault2;
    logic [3:0] retired2;
    logic [3:0] state2;

    snap_t      sb[$];
    stim_t      stq[$];
    snap_t      obs;
    logic [3:0] obs2_state;
    logic [3:0] obs2_ret;
    logic [3:0] exp_ret;
    logic [1:0] exp_flt;
    int         vectors = 0;
    int         miscompares = 0;

    always #5 clk = ~clk;

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4), .HALT_ON_ECALL(1'b1)) dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(mem_req), .mem_we(mem_we), .iord(iord), .ir_write(ir_write), .pc_write(pc_write),
        .reg_write(reg_write), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
        .wb_sel(wb_sel), .pc_src(pc_src), .halted(halted), .fault(fault), .retired(retired),
        .state(state)
    );

    multicycle_control #(.MEM_TIMEOUT(4), .CNT_W(4), .HALT_ON_ECALL(1'b0)) dut_nop (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready), .branch_taken(branch_taken),
        .mem_req(mem_req2), .mem_we(mem_we2), .iord(iord2), .ir_write(ir_write2), .pc_write(pc_write2),
        .reg_write(reg_write2), .alu_src_a(alu_src_a2), .alu_src_b(alu_src_b2), .alu_op(alu_op2),
        .wb_sel(wb_sel2), .pc_src(pc_src2), .halted(halted2), .fault(fault2), .retired(retired2),
        .state(state2)
    );

    // Reference output table for one cycle, written from the state descriptions.
    function automatic snap_t model(state_t s, logic [4:0] op, logic r, logic mr, logic bt,
                                    logic [3:0] ret, logic [1:0] f);
        snap_t m;
        m = '0;
        m.st = s;
        m.retired = ret;
        case (s)
            ST_FETCH:  begin m.mem_req = 1; m.src_b = 2; if (mr) begin m.ir_write = 1; m.pc_write = 1; end end
            ST_DECODE: begin m.src_a = 3; m.src_b = 1; end
            ST_MEMADR: begin m.src_a = 1; m.src_b = 1; end
            ST_MEMRD:  begin m.mem_req = 1; m.iord = 1; end
            ST_MEMWB:  begin m.reg_write = 1; m.wb_sel = 1; end
            ST_MEMWR:  begin m.mem_req = 1; m.mem_we = 1; m.iord = 1; end
            ST_EXEC: begin
                m.src_a = 1;
                if (op == 5'd12) m.alu_op = 2'b10;
                if (op == 5'd4) begin m.src_b = 1; m.alu_op = 2'b11; end
            end
            ST_ALUWB:  m.reg_write = 1;
            ST_BRANCH: begin m.src_a = 1; m.alu_op = 2'b01; m.pc_src = 1; m.pc_write = bt; end
            ST_JUMP: begin
                m.reg_write = 1; m.wb_sel = 2; m.pc_write = 1;
                if (op == 5'd27) m.pc_src = 1;
                if (op == 5'd25) begin m.src_a = 1; m.src_b = 1; end
            end
            ST_UPPER: begin m.src_a = (op == 5'd5) ? 2'd3 : 2'd2; m.src_b = 1; m.reg_write = 1; end
            ST_HALT:  begin m.halted = 1; m.fault = f; end
            default:  m = '0;
        endcase
        if (r) begin
            m.mem_req = 0; m.mem_we = 0; m.ir_write = 0; m.pc_write = 0; m.reg_write = 0;
        end
        return m;
    endfunction

    task automatic push(state_t s, logic r, logic mr, logic bt, logic [4:0] op);
        stim_t st;
        sb.push_back(model(s, op, r, mr, bt, exp_ret, exp_flt));
        st.rst = r; st.mr = mr; st.bt = bt; st.op = op;
        stq.push_back(st);
    endtask

    task automatic drive_one();
        stim_t s;
        s = stq.pop_front();
        rst = s.rst; mem_ready = s.mr; branch_taken = s.bt; opcode = s.op;
        @(negedge clk);
        obs.st = state; obs.mem_req = mem_req; obs.mem_we = mem_we; obs.iord = iord;
        obs.ir_write = ir_write; obs.pc_write = pc_write; obs.reg_write = reg_write;
        obs.src_a = alu_src_a; obs.src_b = alu_src_b; obs.alu_op = alu_op; obs.wb_sel = wb_sel;
        obs.pc_src = pc_src; obs.halted = halted; obs.fault = fault; obs.retired = retired;
        obs2_state = state2; obs2_ret = retired2;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        snap_t e;
        int n = 0;
        exp_ret = 0; exp_flt = 0;
        push(ST_FETCH, 1, 1, 0, 5'd12);
        push(ST_FETCH, 1, 0, 0, 5'd12);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL reset cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_rtype();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 0, 5'd12);
        push(ST_DECODE, 0, 1, 0, 5'd12);
        push(ST_EXEC, 0, 1, 0, 5'd12);
        push(ST_ALUWB, 0, 1, 0, 5'd12);
        exp_ret++;
        push(ST_FETCH, 0, 0, 0, 5'd12);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL rtype cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_load_wait();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 0, 5'd0);
        push(ST_DECODE, 0, 1, 0, 5'd0);
        push(ST_MEMADR, 0, 1, 0, 5'd0);
        for (int i = 0; i < 3; i++) push(ST_MEMRD, 0, 0, 0, 5'd0);
        push(ST_MEMRD, 0, 1, 0, 5'd0);
        push(ST_MEMWB, 0, 0, 0, 5'd0);
        exp_ret++;
        push(ST_FETCH, 0, 0, 0, 5'd0);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL load_wait cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_store();
        snap_t e;
        int n = 0;
        // Ready arriving on the last permitted wait cycle completes normally.
        push(ST_FETCH, 0, 1, 0, 5'd8);
        push(ST_DECODE, 0, 1, 0, 5'd8);
        push(ST_MEMADR, 0, 1, 0, 5'd8);
        for (int i = 0; i < 3; i++) push(ST_MEMWR, 0, 0, 0, 5'd8);
        push(ST_MEMWR, 0, 1, 0, 5'd8);
        exp_ret++;
        push(ST_FETCH, 0, 1, 0, 5'd8);
        push(ST_DECODE, 0, 1, 0, 5'd8);
        push(ST_MEMADR, 0, 1, 0, 5'd8);
        push(ST_MEMWR, 0, 1, 0, 5'd8);
        exp_ret++;
        push(ST_FETCH, 0, 0, 0, 5'd8);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL store cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_branch();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 1, 5'd24);
        push(ST_DECODE, 0, 1, 1, 5'd24);
        push(ST_BRANCH, 0, 1, 1, 5'd24);
        exp_ret++;
        push(ST_FETCH, 0, 1, 0, 5'd24);
        push(ST_DECODE, 0, 1, 0, 5'd24);
        push(ST_BRANCH, 0, 1, 0, 5'd24);
        exp_ret++;
        push(ST_FETCH, 0, 0, 0, 5'd24);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL branch cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_jump_upper();
        snap_t e;
        int n = 0;
        logic [4:0] ops [5];
        ops[0] = 5'd27; ops[1] = 5'd25; ops[2] = 5'd5; ops[3] = 5'd13; ops[4] = 5'd4;
        for (int k = 0; k < 5; k++) begin
            push(ST_FETCH, 0, 1, 0, ops[k]);
            push(ST_DECODE, 0, 1, 0, ops[k]);
            if (ops[k] == 5'd27 || ops[k] == 5'd25) push(ST_JUMP, 0, 1, 0, ops[k]);
            else if (ops[k] == 5'd4) begin
                push(ST_EXEC, 0, 1, 0, ops[k]);
                push(ST_ALUWB, 0, 1, 0, ops[k]);
            end else push(ST_UPPER, 0, 1, 0, ops[k]);
            exp_ret++;
        end
        push(ST_FETCH, 0, 0, 0, 5'd4);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL jump_upper cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_timeout();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 0, 5'd8);
        push(ST_DECODE, 0, 1, 0, 5'd8);
        push(ST_MEMADR, 0, 1, 0, 5'd8);
        for (int i = 0; i < 4; i++) push(ST_MEMWR, 0, 0, 0, 5'd8);
        exp_flt = 2'b10;
        for (int i = 0; i < 3; i++) push(ST_HALT, 0, 1, 0, 5'd12);
        push(ST_HALT, 1, 0, 0, 5'd12);
        exp_flt = 0; exp_ret = 0;
        push(ST_FETCH, 0, 0, 0, 5'd12);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL timeout cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_illegal();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 0, 5'd31);
        push(ST_DECODE, 0, 1, 0, 5'd31);
        exp_flt = 2'b01;
        push(ST_HALT, 0, 1, 0, 5'd31);
        push(ST_HALT, 0, 0, 0, 5'd31);
        push(ST_HALT, 1, 0, 0, 5'd31);
        exp_flt = 0; exp_ret = 0;
        push(ST_FETCH, 0, 0, 0, 5'd31);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL illegal cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    task automatic test_ecall();
        snap_t e;
        int n = 0;
        push(ST_FETCH, 0, 1, 0, 5'd28);
        push(ST_DECODE, 0, 1, 0, 5'd28);
        exp_flt = 2'b11;
        push(ST_HALT, 0, 0, 0, 5'd28);
        push(ST_HALT, 1, 0, 0, 5'd28);
        exp_flt = 0; exp_ret = 0;
        push(ST_FETCH, 0, 0, 0, 5'd28);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL ecall cyc%0d: got %h want %h", n, obs, e); end
            if (n == 2) begin
                // The NOP-configured instance retires SYSTEM and is back in FETCH.
                vectors++;
                if (obs2_state !== 4'd0) begin
                    miscompares++; $display("FAIL ecall_nop_state: got %0d want 0", obs2_state);
                end
                vectors++;
                if (obs2_ret !== 4'd1) begin
                    miscompares++; $display("FAIL ecall_nop_retired: got %0d want 1", obs2_ret);
                end
            end
            n++;
        end
    endtask

    task automatic test_back_to_back_wrap();
        snap_t e;
        int n = 0;
        for (int k = 0; k < 16; k++) begin
            push(ST_FETCH, 0, 1, 0, 5'd12);
            push(ST_DECODE, 0, 1, 0, 5'd12);
            push(ST_EXEC, 0, 1, 0, 5'd12);
            push(ST_ALUWB, 0, 1, 0, 5'd12);
            exp_ret++;
        end
        push(ST_FETCH, 0, 0, 0, 5'd12);
        while (sb.size() > 0) begin
            drive_one(); e = sb.pop_front(); vectors++;
            if (obs !== e) begin miscompares++; $display("FAIL wrap cyc%0d: got %h want %h", n, obs, e); end
            n++;
        end
    endtask

    initial begin
        rst = 1'b1; opcode = 5'd0; mem_ready = 1'b0; branch_taken = 1'b0;
        exp_ret = 0; exp_flt = 0;
        repeat (2) @(posedge clk);
        #1;
        test_reset();
        test_rtype();
        test_load_wait();
        test_store();
        test_branch();
        test_jump_upper();
        test_timeout();
        test_illegal();
        test_ecall();
        test_back_to_back_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
MULTICYCLE_CONTROL -- requirements
Module: multicycle_control

Interface
REQ-001 MEM_TIMEOUT, default 16, consecutive memory-wait cycles before fault (>=1).
REQ-002 CNT_W, default 32, width of retire counter.
REQ-003 HALT_ON_ECALL, default 1: 1 = SYSTEM opcode halts; 0 = SYSTEM retires as NOP.
REQ-004 clk  input  1  sole clock; all state updates on rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 opcode  input  5  instruction bits [6:2] from IR.
REQ-007 mem_ready  input  1  memory completes current request this cycle.
REQ-008 branch_taken  input  1  datapath branch comparison result.
REQ-009 mem_req, mem_we, iord  output  1 each  request, write, address select (0 PC, 1 ALU out).
REQ-010 ir_write, pc_write, reg_write  output  1 each  register enables.
REQ-011 alu_src_a  output  2  (0 PC, 1 rs1, 2 zero, 3 old PC); alu_src_b  output  2  (0 rs2, 1 imm, 2 const 4).
REQ-012 alu_op  output  2  (00 add, 01 branch compare, 10 R-type, 11 I-type).
REQ-013 wb_sel  output  2  (0 ALU, 1 mem data, 2 PC); pc_src  output  1  (0 ALU result, 1 ALU-out register).
REQ-014 halted  output  1; fault  output  2  (00 none, 01 illegal, 10 mem timeout, 11 ecall); retired  output  CNT_W; state  output  4  (debug).

Function
REQ-015 States: FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXEC, ALUWB, BRANCH, JUMP, UPPER, HALT; outputs Moore-decoded from state except where stated.
REQ-016 Outputs not listed for a state SHALL be 0.
REQ-017 FETCH: mem_req=1, iord=0, src_a=0, src_b=2, alu_op=00; on mem_ready: ir_write=1, pc_write=1, pc_src=0, go DECODE; else hold.
REQ-018 DECODE: src_a=3, src_b=1, alu_op=00 (target precompute); next: 0/8 MEMADR; 4/12 EXEC; 24 BRANCH; 25/27 JUMP; 5/13 UPPER; 28 HALT fault 11 (HALT_ON_ECALL=1) else FETCH; any other HALT fault 01.
REQ-019 MEMADR: src_a=1, src_b=1, alu_op=00; go MEMRD if opcode 0, else MEMWR.
REQ-020 MEMRD: mem_req=1, iord=1; mem_ready -> MEMWB. MEMWB: reg_write=1, wb_sel=1 -> FETCH.
REQ-021 MEMWR: mem_req=1, mem_we=1, iord=1; mem_ready -> FETCH.
REQ-022 EXEC: src_a=1; opcode 12: src_b=0, alu_op=10; opcode 4: src_b=1, alu_op=11; -> ALUWB. ALUWB: reg_write=1, wb_sel=0 -> FETCH.
REQ-023 BRANCH: src_a=1, src_b=0, alu_op=01, pc_src=1, pc_write=branch_taken (combinational); -> FETCH.
REQ-024 JUMP: reg_write=1, wb_sel=2, pc_write=1; opcode 27 pc_src=1; opcode 25 src_a=1, src_b=1, alu_op=00, pc_src=0; -> FETCH.
REQ-025 UPPER: src_a=3 (opcode 5) or 2 (opcode 13), src_b=1, alu_op=00, reg_write=1, wb_sel=0; -> FETCH.
REQ-026 Zero-wait latency: load 5 cycles; store, R, I 4; branch, jump, upper 3.
REQ-027 retired increments by 1 on every transition into FETCH from a non-FETCH state; wraps all-ones -> 0; never increments on HALT entry.
REQ-028 Wait counter clears on entering FETCH/MEMRD/MEMWR and on mem_ready; increments each cycle mem_req=1 with mem_ready=0.
REQ-029 Counter reaching MEM_TIMEOUT -> HALT, fault=10; no ir_write/pc_write/reg_write that cycle; mem_ready in the same cycle wins (normal completion).
REQ-030 HALT absorbing until rst: halted=1, all enables 0, fault held; fault is 00 in all other states.

Reset
REQ-031 rst high at rising edge, from any state incl. mid-wait or HALT: state=FETCH, retired=0, wait counter=0, fault=00, halted=0.
REQ-032 While rst high: mem_req, mem_we, ir_write, pc_write, reg_write forced 0; first fetch request in first cycle after rst falls.

Structure
REQ-033 Shared package: 4-bit state enum; opcode constants (LOAD 0, OP_IMM 4, AUIPC 5, STORE 8, OP 12, LUI 13, BRANCH 24, JALR 25, JAL 27, SYSTEM 28); alu_op, alu_src, wb_sel, fault codes.
REQ-034 One sub-module mem_wait_timer (wait counter + MEM_TIMEOUT compare); next-state and output decode stay in multicycle_control.

Verification
REQ-035 opcode=12, mem_ready=1 -> FETCH,DECODE,EXEC,ALUWB,FETCH; reg_write only in ALUWB, alu_op=10; retired 0->1.
REQ-036 opcode=0, mem_ready low 3 cycles in MEMRD -> MEMRD held 4 cycles, MEMWB wb_sel=1, fault=00, retired+1.
REQ-037 MEM_TIMEOUT=4, opcode=8, mem_ready stuck 0 -> HALT after 4 MEMWR wait cycles, fault=10, halted=1, retired unchanged.
REQ-038 opcode=24 twice, branch_taken=1 then 0 -> pc_write 1 then 0 in BRANCH; both return to FETCH.
REQ-039 opcode=31 -> HALT fault=01; opcode=28 -> fault=11 (HALT_ON_ECALL=1) or retire (=0); rst in HALT -> FETCH, fault=00.
REQ-040 CNT_W=4, 16 back-to-back R-type instructions -> retired counts 1..15 then wraps to 0.
